simplebus_req_queue: RTL and testbench
======================================

# simplebus_req_queue

Request queue that sits directly upstream of the simple-bus leader (processor interface thread). It buffers CPU-side read/write requests in a small FIFO, presents them one at a time on the leader's access/doRead/address/write-data controls, tracks each transaction to completion, and returns read data to the CPU through a valid/ready response port.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- AW, 16, address width; matches the leader's 16-bit address register
- DW, 8, data width
- TIMEOUT_CYCLES, 255, watchdog limit; used only when TIMEOUT_EN is defined
- clock  in  1  system clock, rising-edge
- resetN  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  queue can accept; equals !full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data (ignored for reads)
- rsp_valid  out  1  read response held valid
- rsp_ready  in  1  CPU takes response
- rsp_data  out  DW  read data
- rsp_err  out  1  response is a timeout abort (constant 0 without TIMEOUT_EN)
- access  out  1  start pulse to leader
- doRead  out  1  current transaction is a read
- addr_o  out  AW  current transaction address
- wdata_o  out  DW  current write data
- wDataRdy  out  1  write data ready to leader
- done_i  in  1  leader completed a write (one-cycle pulse)
- rdata_vld_i  in  1  leader captured read data (one-cycle pulse)
- rdata_i  in  DW  read data from leader, valid with rdata_vld_i
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: push when req_valid && req_ready; pop when the head transaction finishes (write done, or read response consumed). Head entry drives doRead/addr_o/wdata_o continuously while not empty.
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP.
- IDLE: count≠0 → ISSUE; else stay.
- ISSUE: access=1 for exactly this cycle; → WAIT_WR if head is write, WAIT_RD if read.
- WAIT_WR: wDataRdy=1; done_i → pop, → IDLE.
- WAIT_RD: rdata_vld_i → capture rdata_i into rsp_data, → RESP.
- RESP: rsp_valid=1, data stable; rsp_ready → pop, → IDLE. No new transaction issues while a response is pending.
- done_i/rdata_vld_i outside their wait state are ignored.
- Full: req_ready=0 even if a pop occurs that cycle (no push-through). Empty: no issue.
- Pointers wrap modulo DEPTH; count saturates never (push blocked at DEPTH).

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, access=0, wDataRdy=0, count=0, state IDLE, pointers 0. doRead/addr_o/wdata_o=0 while empty.
- Reset mid-transaction: asynchronously drops access/wDataRdy, discards FIFO and pending response.
- Push→access: request pushed in cycle N into empty queue → IDLE sees count at N+1 → access high in N+2.
- Write retire: pop in the cycle done_i is sampled; next request's access no earlier than 2 cycles later.
- Read: rsp_valid rises the cycle after rdata_vld_i; pop on the rsp_ready handshake edge.
- All outputs registered or decoded from registered state; no combinational path req_* → access.

## Configuration
- TIMEOUT_EN defined: counter reset on entering WAIT_WR/WAIT_RD, increments each wait cycle; reaching TIMEOUT_CYCLES aborts: read → RESP with rsp_err=1, rsp_data=0; write → pop silently and assert rsp_valid with rsp_err=1 for handshake. rsp_err cleared on response consumption.
- Not defined: no counter; waits indefinitely; rsp_err tied 0.

## Test plan
- Write 0x1234←0xA5: access one cycle at N+2, doRead=0, addr_o=0x1234, wDataRdy held until done_i → count returns 0, no rsp_valid.
- Read 0x00FF, rdata_i=0x3C with rdata_vld_i 3 cycles after access → rsp_valid with rsp_data=0x3C, held while rsp_ready=0 for 4 cycles, cleared after handshake.
- Push 5 requests, DEPTH=4, downstream stalled → 4 accepted, req_ready=0, count=4; complete one → req_ready=1 next cycle, in-order issue verified.
- Assert resetN=0 mid-WAIT_RD → access/wDataRdy/rsp_valid 0 immediately, count=0; after release, new request issues normally.
- TIMEOUT_EN, TIMEOUT_CYCLES=8, read never answered → rsp_valid with rsp_err=1, rsp_data=0 after 8 wait cycles; without macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/simplebus_req_queue.sv
// simplebus_req_queue: in-order CPU request FIFO in front of the simple-bus leader,
// returning read data on a valid/ready port. Optional wait watchdog: define TIMEOUT_EN.
module simplebus_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 8
`ifdef TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic                   rsp_err,
  output logic                   access,
  output logic                   doRead,
  output logic [AW-1:0]          addr_o,
  output logic [DW-1:0]          wdata_o,
  output logic                   wDataRdy,
  input  logic                   done_i,
  input  logic                   rdata_vld_i,
  input  logic [DW-1:0]          rdata_i,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          empty, full, push, pop, head_write;
  logic          tmo_hit, rsp_nopop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign head       = mem[rd_ptr];
  assign head_write = head[EW-1];

  // Head entry is presented continuously; forced to zero when nothing is queued
  assign doRead    = !empty && !head_write;
  assign addr_o    = empty ? '0 : head[DW +: AW];
  assign wdata_o   = empty ? '0 : head[DW-1:0];
  assign access    = (state == ISSUE);
  assign wDataRdy  = (state == WAIT_WR);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = head_write ? WAIT_WR : WAIT_RD;
      WAIT_WR: begin
        if (done_i) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          pop       = 1'b1;
          state_nxt = RESP;
        end
      end
      WAIT_RD: if (rdata_vld_i || tmo_hit) state_nxt = RESP;
      RESP: begin
        // An aborted write already left the FIFO; only its error response remains
        if (rsp_ready) begin
          pop       = !rsp_nopop;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (state == WAIT_RD && rdata_vld_i) rsp_data <= rdata_i;
      else if (tmo_hit)                    rsp_data <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  end

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic          waiting;

  assign waiting = (state == WAIT_WR) || (state == WAIT_RD);
  assign tmo_hit = waiting && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      timer     <= '0;
      rsp_err   <= 1'b0;
      rsp_nopop <= 1'b0;
    end else begin
      if (state == ISSUE) timer <= '0;
      else if (waiting)   timer <= timer + TW'(1);
      if (state == WAIT_WR && !done_i && tmo_hit) begin
        rsp_err   <= 1'b1;
        rsp_nopop <= 1'b1;
      end else if (state == WAIT_RD && !rdata_vld_i && tmo_hit) begin
        rsp_err <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_nopop <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign rsp_nopop = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_simplebus_req_queue.sv
// Bench for simplebus_req_queue: directed vector table, corner-case sequences and a
// randomized run against a transaction-level queue model.
module tb_simplebus_req_queue;
  localparam int DEPTH      = 4;
  localparam int AW         = 16;
  localparam int DW         = 8;
  localparam int CW         = $clog2(DEPTH) + 1;
  localparam int RND_CYCLES = 3000;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    int            hold;
    logic          exp_rsp;
    logic          exp_doread;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          access;
  logic          doRead;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          wDataRdy;
  logic          done_i = 1'b0;
  logic          rdata_vld_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic [CW-1:0] count;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[5];

  always #5 clock = ~clock;

  simplebus_req_queue #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
`ifdef TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .access(access), .doRead(doRead), .addr_o(addr_o), .wdata_o(wdata_o),
    .wDataRdy(wDataRdy), .done_i(done_i), .rdata_vld_i(rdata_vld_i), .rdata_i(rdata_i),
    .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_access(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = access;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    resetN = 1'b1;
    tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    check($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check($sformatf("v%0d_count1", idx), 32'(count), 32'd1);
    check($sformatf("v%0d_acc_early", idx), 32'(access), 32'd0);
    tick();
    check($sformatf("v%0d_access", idx), 32'(access), 32'd1);
    check($sformatf("v%0d_doread", idx), 32'(doRead), 32'(v.exp_doread));
    check($sformatf("v%0d_addr", idx), 32'(addr_o), 32'(v.addr));
    check($sformatf("v%0d_wdata", idx), 32'(wdata_o), 32'(v.wdata));
    tick();
    check($sformatf("v%0d_acc_once", idx), 32'(access), 32'd0);
    check($sformatf("v%0d_wrdy", idx), 32'(wDataRdy), 32'(v.write));
    for (int k = 1; k < v.lat; k++) begin
      tick();
      check($sformatf("v%0d_wrdy_hold", idx), 32'(wDataRdy), 32'(v.write));
      check($sformatf("v%0d_no_rsp", idx), 32'(rsp_valid), 32'd0);
    end
    if (v.write) done_i = 1'b1;
    else begin
      rdata_vld_i = 1'b1;
      rdata_i     = v.rdata;
    end
    tick();
    done_i      = 1'b0;
    rdata_vld_i = 1'b0;
    rdata_i     = 8'h5A;
    check($sformatf("v%0d_wrdy_off", idx), 32'(wDataRdy), 32'd0);
    check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'(v.exp_rsp));
    if (v.exp_rsp) begin
      check($sformatf("v%0d_rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
      check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'd0);
      for (int k = 0; k < v.hold; k++) begin
        tick();
        check($sformatf("v%0d_rsp_hold", idx), 32'(rsp_valid), 32'd1);
        check($sformatf("v%0d_data_hold", idx), 32'(rsp_data), 32'(v.exp_data));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_clear", idx), 32'(rsp_valid), 32'd0);
    end
    check($sformatf("v%0d_count0", idx), 32'(count), 32'd0);
  endtask

  task automatic fill_test();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0100 + 16'(i);
      req_wdata = 8'h10 + 8'(i);
      check($sformatf("fill_ready%0d", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready_low", 32'(req_ready), 32'd0);
    check("fill_head_addr", 32'(addr_o), 32'h0100);
    check("fill_wrdy", 32'(wDataRdy), 32'd1);
    // pop while full: the offered request must still be refused
    req_addr = 16'h0104;
    done_i   = 1'b1;
    tick();
    done_i    = 1'b0;
    req_valid = 1'b0;
    check("fill_no_pushthru", 32'(count), 32'd3);
    check("fill_ready_back", 32'(req_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      wait_access($sformatf("fill_acc%0d", k));
      check($sformatf("fill_order_addr%0d", k), 32'(addr_o), 32'h0100 + 32'(k));
      check($sformatf("fill_order_data%0d", k), 32'(wdata_o), 32'h10 + 32'(k));
      tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      check($sformatf("fill_drain%0d", k), 32'(count), 32'(3 - k));
    end
  endtask

  task automatic reset_tests();
    push_one(1'b0, 16'h0042, 8'h00);
    wait_access("rst1_acc");
    tick();
    tick();
    check("rst1_pre_count", 32'(count), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("rst1_access", 32'(access), 32'd0);
    check("rst1_wrdy", 32'(wDataRdy), 32'd0);
    check("rst1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst1_count", 32'(count), 32'd0);
    check("rst1_doread", 32'(doRead), 32'd0);
    check("rst1_addr", 32'(addr_o), 32'd0);
    release_reset();

    push_one(1'b1, 16'h0043, 8'h77);
    wait_access("rst2_acc");
    #2 resetN = 1'b0;
    #1;
    check("rst2_access", 32'(access), 32'd0);
    check("rst2_count", 32'(count), 32'd0);
    release_reset();

    push_one(1'b0, 16'h0044, 8'h00);
    wait_access("rst3_acc");
    tick();
    rdata_vld_i = 1'b1;
    rdata_i     = 8'h66;
    tick();
    rdata_vld_i = 1'b0;
    check("rst3_rsp_pre", 32'(rsp_valid), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("rst3_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst3_rsp_data", 32'(rsp_data), 32'd0);
    release_reset();
  endtask

  task automatic random_test();
    req_t          q[$];
    req_t          r_d;
    bit            d_push = 0, d_popw = 0, d_popr = 0, d_rd = 0;
    bit            busy = 0, cur_write = 0, mpend = 0;
    logic [DW-1:0] d_rdata = '0;
    logic [DW-1:0] mdata = '0;
    int            acc_cyc = 0, lat = 0, naccess = 0;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    done_i      = 1'b0;
    rdata_vld_i = 1'b0;
    for (int c = 0; c < RND_CYCLES + 200; c++) begin
      tick();
      if (d_popw || d_popr) void'(q.pop_front());
      if (d_push) q.push_back(r_d);
      if (d_rd) begin
        mpend = 1'b1;
        mdata = d_rdata;
      end
      if (d_popr) mpend = 1'b0;

      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(mpend));
      if (mpend) check("rnd_rsp_data", 32'(rsp_data), 32'(mdata));
      check("rnd_rsp_err", 32'(rsp_err), 32'd0);
      if (q.size() > 0) begin
        check("rnd_doread", 32'(doRead), 32'(!q[0].write));
        check("rnd_addr", 32'(addr_o), 32'(q[0].addr));
        check("rnd_wdata", 32'(wdata_o), 32'(q[0].wdata));
      end else begin
        check("rnd_idle_outs", 32'({doRead, addr_o, wdata_o}), 32'd0);
      end
      check("rnd_wrdy", 32'(wDataRdy), 32'(busy && cur_write && (c > acc_cyc)));
      if (access) begin
        check("rnd_access_legal", 32'(!busy && !mpend && (q.size() > 0)), 32'd1);
        naccess++;
        busy      = 1'b1;
        acc_cyc   = c;
        lat       = $urandom_range(1, 6);
        cur_write = (q.size() > 0) ? q[0].write : 1'b0;
      end

      d_push = 0; d_popw = 0; d_popr = 0; d_rd = 0;
      done_i      = 1'b0;
      rdata_vld_i = 1'b0;
      rdata_i     = 8'($urandom);
      if (c < RND_CYCLES) begin
        req_valid = ($urandom_range(0, 2) == 0);
        rsp_ready = ($urandom_range(0, 1) == 1);
      end else begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      if (busy && c == acc_cyc + lat) begin
        if (cur_write) begin
          done_i = 1'b1;
          d_popw = 1;
        end else begin
          rdata_vld_i = 1'b1;
          d_rd        = 1;
          d_rdata     = rdata_i;
        end
        busy = 1'b0;
      end else if ((!busy || c == acc_cyc) && $urandom_range(0, 7) == 0) begin
        done_i      = 1'($urandom_range(0, 1));
        rdata_vld_i = !done_i;
      end
      d_push = req_valid && (q.size() < DEPTH);
      r_d    = '{req_write, req_addr, req_wdata};
      d_popr = rsp_ready && mpend;
    end
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    done_i      = 1'b0;
    rdata_vld_i = 1'b0;
    tick();
    check("rnd_drained", 32'(q.size()), 32'd0);
    check("rnd_count_end", 32'(count), 32'd0);
    check("rnd_activity", 32'(naccess > 50), 32'd1);
  endtask

  task automatic timeout_test();
`ifdef TIMEOUT_EN
    push_one(1'b0, 16'h0777, 8'h00);
    wait_access("tmo_rd_acc");
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("tmo_rd_waiting", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("tmo_rd_valid", 32'(rsp_valid), 32'd1);
    check("tmo_rd_err", 32'(rsp_err), 32'd1);
    check("tmo_rd_data", 32'(rsp_data), 32'd0);
    check("tmo_rd_count", 32'(count), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tmo_rd_clear", 32'(rsp_valid), 32'd0);
    check("tmo_rd_err_clr", 32'(rsp_err), 32'd0);
    check("tmo_rd_count0", 32'(count), 32'd0);

    push_one(1'b1, 16'h0888, 8'h12);
    wait_access("tmo_wr_acc");
    repeat (9) tick();
    check("tmo_wr_count", 32'(count), 32'd0);
    check("tmo_wr_valid", 32'(rsp_valid), 32'd1);
    check("tmo_wr_err", 32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tmo_wr_clear", 32'(rsp_valid), 32'd0);
    check("tmo_wr_err_clr", 32'(rsp_err), 32'd0);
    check("tmo_wr_count0", 32'(count), 32'd0);
`else
    push_one(1'b0, 16'h0F0F, 8'h00);
    wait_access("nto_acc");
    repeat (1000) tick();
    check("nto_no_rsp", 32'(rsp_valid), 32'd0);
    check("nto_count", 32'(count), 32'd1);
    check("nto_err", 32'(rsp_err), 32'd0);
    check("nto_no_reissue", 32'(access), 32'd0);
    rdata_vld_i = 1'b1;
    rdata_i     = 8'h99;
    tick();
    rdata_vld_i = 1'b0;
    check("nto_late_valid", 32'(rsp_valid), 32'd1);
    check("nto_late_data", 32'(rsp_data), 32'h99);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("nto_count0", 32'(count), 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 4, 0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 16'h00FF, 8'h00, 8'h3C, 3, 4, 1'b1, 1'b1, 8'h3C};
    vecs[2] = '{1'b1, 16'hFFFF, 8'hFF, 8'h00, 1, 0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'hFF, 1, 0, 1'b1, 1'b1, 8'hFF};
    vecs[4] = '{1'b0, 16'h8001, 8'h00, 8'hC3, 5, 1, 1'b1, 1'b1, 8'hC3};

    resetN = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_access", 32'(access), 32'd0);
    check("rst_wrdy", 32'(wDataRdy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_head", 32'({doRead, addr_o, wdata_o}), 32'd0);
    resetN = 1'b1;
    tick();
    check("post_rst_access", 32'(access), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    fill_test();
    reset_tests();
    run_vec(5, vecs[0]);
    random_test();
    timeout_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
